// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from MEM/WB
// and load-use hazard detection reported back to decode.
module alu_operand_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   rd1D,
  input  logic [WIDTH-1:0]   rd2D,
  input  logic [REGBITS-1:0] rsD,
  input  logic [REGBITS-1:0] rtD,
  input  logic [REGBITS-1:0] rdD,
  input  logic [WIDTH-1:0]   signimmD,
  input  logic [4:0]         shamtD,
  input  logic [3:0]         alucontrolD,
  input  logic               alusrcD,
  input  logic               regdstD,
  input  logic               regwriteD,
  input  logic               memwriteD,
  input  logic               memtoregD,
  input  logic               regwriteM,
  input  logic [REGBITS-1:0] writeregM,
  input  logic [WIDTH-1:0]   aluoutM,
  input  logic               regwriteW,
  input  logic [REGBITS-1:0] writeregW,
  input  logic [WIDTH-1:0]   resultW,
  output logic [WIDTH-1:0]   srcaE,
  output logic [WIDTH-1:0]   srcbE,
  output logic [WIDTH-1:0]   writedataE,
  output logic [4:0]         shamtE,
  output logic [3:0]         alucontrolE,
  output logic [REGBITS-1:0] writeregE,
  output logic               regwriteE,
  output logic               memwriteE,
  output logic               memtoregE,
  output logic               validE,
  output logic [1:0]         forwardaE,
  output logic [1:0]         forwardbE,
  output logic               lwstallD
);

  logic [WIDTH-1:0]   r_rd1;
  logic [WIDTH-1:0]   r_rd2;
  logic [WIDTH-1:0]   r_signimm;
  logic [REGBITS-1:0] r_rs;
  logic [REGBITS-1:0] r_rt;
  logic [REGBITS-1:0] r_writereg;
  logic [4:0]         r_shamt;
  logic [3:0]         r_alucontrol;
  logic               r_alusrc;
  logic               r_regwrite;
  logic               r_memwrite;
  logic               r_memtoreg;
  logic               r_valid;

  logic [1:0]         w_fwda;
  logic [1:0]         w_fwdb;
  logic [WIDTH-1:0]   w_srca;
  logic [WIDTH-1:0]   w_writedata;
  logic               w_lwstall;

  // EX register bank: reset/flush load a side-effect-free bubble, stall holds
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_signimm    <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_writereg   <= '0;
      r_shamt      <= '0;
      r_alucontrol <= '0;
      r_alusrc     <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_valid      <= 1'b0;
    end else if (!stall) begin
      r_rd1        <= rd1D;
      r_rd2        <= rd2D;
      r_signimm    <= signimmD;
      r_rs         <= rsD;
      r_rt         <= rtD;
      r_writereg   <= regdstD ? rdD : rtD;
      r_shamt      <= shamtD;
      r_alucontrol <= alucontrolD;
      r_alusrc     <= alusrcD;
      r_regwrite   <= regwriteD;
      r_memwrite   <= memwriteD;
      r_memtoreg   <= memtoregD;
      r_valid      <= 1'b1;
    end
  end

  // Forward select: MEM beats WB, register 0 is hard-wired and never forwarded
  always_comb begin
    w_fwda = 2'b00;
    w_fwdb = 2'b00;
    if (regwriteM && (writeregM != '0) && (writeregM == r_rs))
      w_fwda = 2'b10;
    else if (regwriteW && (writeregW != '0) && (writeregW == r_rs))
      w_fwda = 2'b01;
    if (regwriteM && (writeregM != '0) && (writeregM == r_rt))
      w_fwdb = 2'b10;
    else if (regwriteW && (writeregW != '0) && (writeregW == r_rt))
      w_fwdb = 2'b01;
  end

  always_comb begin
    w_srca      = r_rd1;
    w_writedata = r_rd2;
    case (w_fwda)
      2'b10:   w_srca = aluoutM;
      2'b01:   w_srca = resultW;
      default: w_srca = r_rd1;
    endcase
    case (w_fwdb)
      2'b10:   w_writedata = aluoutM;
      2'b01:   w_writedata = resultW;
      default: w_writedata = r_rd2;
    endcase
  end

  // Gated by reset so a load still sitting in EX cannot raise a stall while resetting
  assign w_lwstall = !reset && r_valid && r_memtoreg && r_regwrite &&
                     (r_writereg != '0) &&
                     ((r_writereg == rsD) || (r_writereg == rtD));

  assign srcaE       = w_srca;
  assign writedataE  = w_writedata;
  assign srcbE       = r_alusrc ? r_signimm : w_writedata;
  assign shamtE      = r_shamt;
  assign alucontrolE = r_alucontrol;
  assign writeregE   = r_writereg;
  assign regwriteE   = r_regwrite;
  assign memwriteE   = r_memwrite;
  assign memtoregE   = r_memtoreg;
  assign validE      = r_valid;
  assign forwardaE   = w_fwda;
  assign forwardbE   = w_fwdb;
  assign lwstallD    = w_lwstall;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand-written hazard
// sequences, then random traffic against a transaction-level model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] rd1D, rd2D, signimmD, aluoutM, resultW;
  logic [4:0]  rsD, rtD, rdD, shamtD, writeregM, writeregW;
  logic [3:0]  alucontrolD;
  logic        alusrcD, regdstD, regwriteD, memwriteD, memtoregD;
  logic        regwriteM, regwriteW;
  logic [31:0] srcaE, srcbE, writedataE;
  logic [4:0]  shamtE, writeregE;
  logic [3:0]  alucontrolE;
  logic        regwriteE, memwriteE, memtoregE, validE, lwstallD;
  logic [1:0]  forwardaE, forwardbE;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .rd1D(rd1D), .rd2D(rd2D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .signimmD(signimmD), .shamtD(shamtD), .alucontrolD(alucontrolD),
    .alusrcD(alusrcD), .regdstD(regdstD), .regwriteD(regwriteD),
    .memwriteD(memwriteD), .memtoregD(memtoregD),
    .regwriteM(regwriteM), .writeregM(writeregM), .aluoutM(aluoutM),
    .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW),
    .srcaE(srcaE), .srcbE(srcbE), .writedataE(writedataE),
    .shamtE(shamtE), .alucontrolE(alucontrolE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .memtoregE(memtoregE),
    .validE(validE), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .lwstallD(lwstallD)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic [4:0]  rs, rt, rd, shamt;
    logic        regdst;
    logic [31:0] rd1, rd2, imm;
    logic        alusrc;
    logic [3:0]  aluc;
    logic        regw, memw, memtoreg;
    logic        regwM;
    logic [4:0]  wrM;
    logic [31:0] aluoutM;
    logic        regwW;
    logic [4:0]  wrW;
    logic [31:0] resultW;
    logic [31:0] e_srca, e_srcb, e_wd;
    logic [1:0]  e_fwa, e_fwb;
    logic        e_valid, e_lw;
    logic [4:0]  e_wr;
  } vec_t;

  // Instruction currently held in EX, as the model sees it
  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, wr, shamt;
    logic [3:0]  aluc;
    logic        alusrc, regw, memw, memtoreg;
  } ex_t;

  ex_t  m;
  vec_t vecs[12];
  vec_t v;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    reset = x.rst; stall = x.stall; flush = x.flush;
    rsD = x.rs; rtD = x.rt; rdD = x.rd; shamtD = x.shamt; regdstD = x.regdst;
    rd1D = x.rd1; rd2D = x.rd2; signimmD = x.imm; alusrcD = x.alusrc;
    alucontrolD = x.aluc; regwriteD = x.regw; memwriteD = x.memw; memtoregD = x.memtoreg;
    regwriteM = x.regwM; writeregM = x.wrM; aluoutM = x.aluoutM;
    regwriteW = x.regwW; writeregW = x.wrW; resultW = x.resultW;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset || flush) begin
      m = '{default:'0};
    end else if (!stall) begin
      m.valid = 1'b1; m.rd1 = rd1D; m.rd2 = rd2D; m.imm = signimmD;
      m.rs = rsD; m.rt = rtD; m.wr = regdstD ? rdD : rtD; m.shamt = shamtD;
      m.aluc = alucontrolD; m.alusrc = alusrcD; m.regw = regwriteD;
      m.memw = memwriteD; m.memtoreg = memtoregD;
    end
    #1;
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (regwriteM && writeregM != 5'd0 && writeregM == src) return 2'b10;
    if (regwriteW && writeregW != 5'd0 && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_val(input logic [1:0] sel, input logic [31:0] regval);
    if (sel == 2'b10) return aluoutM;
    if (sel == 2'b01) return resultW;
    return regval;
  endfunction

  task automatic check_model();
    logic [1:0]  fa, fb;
    logic [31:0] wd;
    logic        lw;
    fa = model_fwd(m.rs);
    fb = model_fwd(m.rt);
    wd = model_val(fb, m.rd2);
    lw = !reset && m.valid && m.memtoreg && m.regw && m.wr != 5'd0 &&
         (m.wr == rsD || m.wr == rtD);
    chk("rnd_srca", srcaE, model_val(fa, m.rd1));
    chk("rnd_wdata", writedataE, wd);
    chk("rnd_srcb", srcbE, m.alusrc ? m.imm : wd);
    chk("rnd_fwda", 32'(forwardaE), 32'(fa));
    chk("rnd_fwdb", 32'(forwardbE), 32'(fb));
    chk("rnd_lwstall", 32'(lwstallD), 32'(lw));
    chk("rnd_valid", 32'(validE), 32'(m.valid));
    chk("rnd_writereg", 32'(writeregE), 32'(m.wr));
    chk("rnd_shamt", 32'(shamtE), 32'(m.shamt));
    chk("rnd_aluc", 32'(alucontrolE), 32'(m.aluc));
    chk("rnd_ctrl", 32'({regwriteE, memwriteE, memtoregE}), 32'({m.regw, m.memw, m.memtoreg}));
  endtask

  task automatic randomize_mw();
    v.regwM = 1'($urandom_range(0, 1)); v.wrM = 5'($urandom_range(0, 3)); v.aluoutM = $urandom();
    v.regwW = 1'($urandom_range(0, 1)); v.wrW = 5'($urandom_range(0, 3)); v.resultW = $urandom();
    v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
  endtask

  initial begin
    m = '{default:'0};
    vecs[0]  = '{rst:1'b1, default:'0};
    vecs[1]  = '{rst:1'b1, default:'0};
    vecs[2]  = '{rs:5'd1, rt:5'd2, rd:5'd3, regdst:1'b1, rd1:32'd5, rd2:32'd7, aluc:4'b0010,
                 regw:1'b1, e_srca:32'd5, e_srcb:32'd7, e_wd:32'd7, e_valid:1'b1, e_wr:5'd3,
                 default:'0};
    vecs[3]  = '{rs:5'd8, rt:5'd8, rd1:32'd1, rd2:32'd2, regw:1'b1, regwM:1'b1, wrM:5'd8,
                 aluoutM:32'hA, regwW:1'b1, wrW:5'd8, resultW:32'hB, e_srca:32'hA, e_srcb:32'hA,
                 e_wd:32'hA, e_fwa:2'b10, e_fwb:2'b10, e_valid:1'b1, e_wr:5'd8, default:'0};
    vecs[4]  = '{rs:5'd4, rt:5'd5, rd1:32'h11, rd2:32'h22, regwM:1'b1, wrM:5'd6, aluoutM:32'h99,
                 regwW:1'b1, wrW:5'd5, resultW:32'h33, e_srca:32'h11, e_srcb:32'h33, e_wd:32'h33,
                 e_fwb:2'b01, e_valid:1'b1, e_wr:5'd5, default:'0};
    vecs[5]  = '{rd1:32'h55, rd2:32'h66, regwM:1'b1, aluoutM:32'hFFFF_FFFF, regwW:1'b1,
                 resultW:32'h44, e_srca:32'h55, e_srcb:32'h66, e_wd:32'h66, e_valid:1'b1,
                 default:'0};
    vecs[6]  = '{rs:5'd3, rt:5'd7, rd:5'd12, regdst:1'b1, rd1:32'h10, rd2:32'd9, alusrc:1'b1,
                 imm:32'hFFFF_FFFC, regwM:1'b1, wrM:5'd7, aluoutM:32'h77, regwW:1'b1, wrW:5'd3,
                 resultW:32'h88, e_srca:32'h88, e_srcb:32'hFFFF_FFFC, e_wd:32'h77, e_fwa:2'b01,
                 e_fwb:2'b10, e_valid:1'b1, e_wr:5'd12, default:'0};
    vecs[7]  = '{rs:5'd8, rt:5'd8, rd1:32'h1, rd2:32'h2, wrM:5'd8, aluoutM:32'hA, wrW:5'd8,
                 resultW:32'hB, e_srca:32'h1, e_srcb:32'h2, e_wd:32'h2, e_valid:1'b1, e_wr:5'd8,
                 default:'0};
    vecs[8]  = '{stall:1'b1, flush:1'b1, rs:5'd2, rt:5'd3, rd1:32'hDEAD, regw:1'b1, default:'0};
    vecs[9]  = '{rs:5'd1, rt:5'd2, rd1:32'h21, rd2:32'h31, alusrc:1'b1, imm:32'hFFFF_FFFC,
                 e_srca:32'h21, e_srcb:32'hFFFF_FFFC, e_wd:32'h31, e_valid:1'b1, e_wr:5'd2,
                 default:'0};
    vecs[10] = '{stall:1'b1, rs:5'd5, rd1:32'h999, regwM:1'b1, wrM:5'd1, aluoutM:32'h5A,
                 e_srca:32'h5A, e_srcb:32'hFFFF_FFFC, e_wd:32'h31, e_fwa:2'b10, e_valid:1'b1,
                 e_wr:5'd2, default:'0};
    vecs[11] = '{flush:1'b1, rs:5'd6, rt:5'd6, rd1:32'h123, regw:1'b1, default:'0};

    v = '{rst:1'b1, default:'0};
    apply(v);
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      tick();
      chk($sformatf("vec%0d_srca", i), srcaE, vecs[i].e_srca);
      chk($sformatf("vec%0d_srcb", i), srcbE, vecs[i].e_srcb);
      chk($sformatf("vec%0d_wdata", i), writedataE, vecs[i].e_wd);
      chk($sformatf("vec%0d_fwda", i), 32'(forwardaE), 32'(vecs[i].e_fwa));
      chk($sformatf("vec%0d_fwdb", i), 32'(forwardbE), 32'(vecs[i].e_fwb));
      chk($sformatf("vec%0d_valid", i), 32'(validE), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_writereg", i), 32'(writeregE), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d_lwstall", i), 32'(lwstallD), 32'(vecs[i].e_lw));
    end

    // Load-use: lw to r9 in EX, decode reads r9
    v = '{rs:5'd1, rt:5'd9, regw:1'b1, memtoreg:1'b1, default:'0};
    apply(v); tick();
    v.rs = 5'd9; v.rt = 5'd0; apply(v); #1;
    chk("lu_rs_hit", 32'(lwstallD), 32'd1);
    v.rs = 5'd2; v.rt = 5'd9; apply(v); #1;
    chk("lu_rt_hit", 32'(lwstallD), 32'd1);
    v.rs = 5'd3; v.rt = 5'd4; apply(v); #1;
    chk("lu_no_hit", 32'(lwstallD), 32'd0);
    v.rs = 5'd9; v.stall = 1'b1; v.rd1 = 32'h777; v.memtoreg = 1'b0; v.regw = 1'b0;
    apply(v); tick();
    chk("lu_hold_valid", 32'(validE), 32'd1);
    chk("lu_hold_wr", 32'(writeregE), 32'd9);
    chk("lu_hold_memtoreg", 32'(memtoregE), 32'd1);
    chk("lu_hold_lwstall", 32'(lwstallD), 32'd1);
    v.stall = 1'b0; v.flush = 1'b1; apply(v); tick();
    chk("lu_flush_valid", 32'(validE), 32'd0);
    chk("lu_flush_lwstall", 32'(lwstallD), 32'd0);
    chk("lu_flush_ctrl", 32'({regwriteE, memwriteE, memtoregE}), 32'd0);

    // A load to r0 or without regwrite never stalls
    v = '{rt:5'd0, regw:1'b1, memtoreg:1'b1, default:'0};
    apply(v); tick();
    chk("lu_r0", 32'(lwstallD), 32'd0);
    v = '{rs:5'd9, rt:5'd9, memtoreg:1'b1, default:'0};
    apply(v); tick();
    chk("lu_noregw", 32'(lwstallD), 32'd0);

    // Reset arriving with a live load in EX
    v = '{rs:5'd9, rt:5'd9, regw:1'b1, memtoreg:1'b1, rd1:32'h4444, default:'0};
    apply(v); tick();
    chk("rst_pre_lwstall", 32'(lwstallD), 32'd1);
    v.rst = 1'b1; apply(v); #1;
    chk("rst_during_lwstall", 32'(lwstallD), 32'd0);
    tick();
    chk("rst_valid", 32'(validE), 32'd0);
    chk("rst_srca", srcaE, 32'd0);
    chk("rst_wr", 32'(writeregE), 32'd0);

    for (int i = 0; i < 400; i++) begin
      v = '{default:'0};
      v.rst = ($urandom_range(0, 39) == 0);
      v.stall = ($urandom_range(0, 4) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.rd = 5'($urandom_range(0, 3)); v.shamt = 5'($urandom());
      v.regdst = 1'($urandom()); v.rd1 = $urandom(); v.rd2 = $urandom(); v.imm = $urandom();
      v.alusrc = 1'($urandom()); v.aluc = 4'($urandom());
      v.regw = 1'($urandom()); v.memw = 1'($urandom()); v.memtoreg = 1'($urandom());
      randomize_mw();
      apply(v); tick();
      check_model();
      randomize_mw();
      apply(v); #1;
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
